mc_maindec: RTL
===============

# mc_maindec

Multicycle main control FSM for the MIPS32 core. It replaces the single-cycle opcode decoder when the datapath shares one memory port and reuses the ALU for PC increment, branch target and effective address. It sequences each instruction over 3–5 states and drives every datapath mux and write enable as a Moore function of state. An optional memory-ready handshake and optional extended opcodes are selected by parameter.

## Interface
- MEM_WAIT, 0: 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored, one cycle each.
- EXT_OPS, 0: 1 = also decode BNE (000101), ANDI (001100), ORI (001101); 0 = these are illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; state forced to FETCH.
- op  in  6  opcode from instruction register; stable from DECODE until next FETCH.
- mem_ready  in  1  memory access complete (used only when MEM_WAIT=1).
- pcwrite, irwrite, regwrite, memwrite  out  1 each  write enables.
- mem_req  out  1  memory access active (FETCH, MEMRD, MEMWR).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = SignImm (ZeroImm when zeroext), 11 = SignImm<<2.
- zeroext  out  1  zero-extend immediate (ANDI/ORI).
- regdst, memtoreg  out  1 each  writeback selects.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- branch, branch_ne  out  1 each  conditional PC write on zero / not-zero.
- aluop  out  2  00 add, 01 sub, 10 use funct, 11 logical immediate.
- logic_or  out  1  with aluop=11: 1 = OR, 0 = AND (equals op[0]).
- illegal  out  1  one-cycle pulse in DECODE on an unsupported op.
- state  out  4  current state encoding (debug).

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12, LOGIEX=13. Codes 14–15 go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op: 000000→RTYPEEX, 100011/101011→MEMADR, 000100→BEQEX, 001000→ADDIEX, 000010→JEX.
  - With EXT_OPS=1: 000101→BNEEX, 001100/001101→LOGIEX.
  - Any other op in DECODE: illegal=1, →FETCH.
  - MEMADR→MEMRD (LW) or MEMWR (SW). MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB. ADDIEX and LOGIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX→FETCH.
- Outputs per state. Unlisted signals are 0.
  - FETCH: alusrcb=01, irwrite=1, pcwrite=1, mem_req=1.
  - DECODE: alusrcb=11.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10.
  - MEMRD: iord=1, mem_req=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1, mem_req=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - BNEEX: same as BEQEX with branch_ne=1 and branch=0.
  - LOGIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=11, logic_or=op[0].
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- MEM_WAIT=1:
  - FETCH, MEMRD and MEMWR advance only when mem_ready=1.
  - In FETCH, irwrite and pcwrite are asserted only in the cycle with mem_ready=1.
  - memwrite and mem_req stay high for the whole wait.

## Timing
- Next-state register is updated on the rising clk edge. Outputs are combinational from state (plus mem_ready gating in FETCH).
- Reset: state=0 (FETCH) immediately, without waiting for clk.
  - While reset is high, pcwrite, irwrite, regwrite, memwrite, mem_req and illegal are forced to 0.
  - Selects take their FETCH values: alusrcb=01, all others 0.
- First fetch completes on the first clk edge after reset deasserts.
- Cycles per instruction with MEM_WAIT=0: LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3, illegal 2.
- With MEM_WAIT=1, add one cycle per memory state for each cycle mem_ready is low.
- Reset mid-instruction aborts it. No write enable stays asserted after reset.
- op changing outside DECODE/MEMADR/LOGIEX has no effect.

## Test plan
- Reset held, then released; op=000000, MEM_WAIT=0 → state 0,1,6,7,0. regwrite=1 and regdst=1 only in state 7. pcwrite=irwrite=1 only in state 0.
- LW (op=100011) → states 0,1,2,3,4,0. iord=1 in state 3. memtoreg=regwrite=1 in state 4. SW (101011) → states 0,1,2,5,0 with memwrite=1 only in state 5.
- MEM_WAIT=1, SW with mem_ready low for 3 cycles in MEMWR → state 5 held 4 cycles with memwrite=1 throughout. In FETCH, pcwrite=irwrite=0 until mem_ready=1.
- EXT_OPS=0, op=000101 → illegal=1 for one cycle in DECODE, then FETCH. EXT_OPS=1, op=000101 → state 12 with branch_ne=1, branch=0, pcsrc=01.
- EXT_OPS=1, op=001101 → state 13 with aluop=11, zeroext=1, logic_or=1, then state 10 with regwrite=1. op=001100 → logic_or=0.
- Assert reset asynchronously (between edges) during MEMWR → state=0 and memwrite=0 before the next clk edge. J (000010) afterwards → states 0,1,11 with pcsrc=10 and pcwrite=1.

Source files
------------

// File: rtl/mc_maindec.sv
// Multicycle MIPS32 main control FSM: sequences each instruction over 3-5 states
// and drives datapath selects/enables as a Moore function of state.
module mc_maindec #(
  parameter bit MEM_WAIT = 1'b0,
  parameter bit EXT_OPS  = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic       pcwrite_o,
  output logic       irwrite_o,
  output logic       regwrite_o,
  output logic       memwrite_o,
  output logic       mem_req_o,
  output logic       iord_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic       zeroext_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic [1:0] pcsrc_o,
  output logic       branch_o,
  output logic       branch_ne_o,
  output logic [1:0] aluop_o,
  output logic       logic_or_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11,
    S_BNEEX   = 4'd12, S_LOGIEX  = 4'd13
  } state_e;

  state_e state_q, state_d;
  logic   dec_illegal;
  logic   mem_go;

  // Without the handshake every memory state lasts exactly one cycle.
  assign mem_go  = MEM_WAIT ? mem_ready_i : 1'b1;
  assign state_o = state_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    dec_illegal = 1'b0;
    case (state_q)
      S_FETCH:   state_d = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          6'b000000:            state_d = S_RTYPEEX;
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000100:            state_d = S_BEQEX;
          6'b001000:            state_d = S_ADDIEX;
          6'b000010:            state_d = S_JEX;
          6'b000101: if (EXT_OPS) state_d = S_BNEEX; else dec_illegal = 1'b1;
          6'b001100, 6'b001101: if (EXT_OPS) state_d = S_LOGIEX; else dec_illegal = 1'b1;
          default:              dec_illegal = 1'b1;
        endcase
      end
      // op[3] separates SW (101011) from LW (100011).
      S_MEMADR:  state_d = op_i[3] ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_go ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_LOGIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite_o   = 1'b0; irwrite_o  = 1'b0; regwrite_o = 1'b0; memwrite_o  = 1'b0;
    mem_req_o   = 1'b0; iord_o     = 1'b0; alusrca_o  = 1'b0; alusrcb_o   = 2'b00;
    zeroext_o   = 1'b0; regdst_o   = 1'b0; memtoreg_o = 1'b0; pcsrc_o     = 2'b00;
    branch_o    = 1'b0; branch_ne_o = 1'b0; aluop_o   = 2'b00; logic_or_o = 1'b0;
    illegal_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_o = 2'b01; mem_req_o = 1'b1;
        irwrite_o = mem_go; pcwrite_o = mem_go;
      end
      S_DECODE: begin
        alusrcb_o = 2'b11; illegal_o = dec_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_o = 1'b1; alusrcb_o = 2'b10;
      end
      S_MEMRD:   begin iord_o = 1'b1; mem_req_o = 1'b1; end
      S_MEMWB:   begin memtoreg_o = 1'b1; regwrite_o = 1'b1; end
      S_MEMWR:   begin iord_o = 1'b1; memwrite_o = 1'b1; mem_req_o = 1'b1; end
      S_RTYPEEX: begin alusrca_o = 1'b1; aluop_o = 2'b10; end
      S_RTYPEWB: begin regdst_o = 1'b1; regwrite_o = 1'b1; end
      S_BEQEX, S_BNEEX: begin
        alusrca_o = 1'b1; aluop_o = 2'b01; pcsrc_o = 2'b01;
        branch_o = (state_q == S_BEQEX); branch_ne_o = (state_q == S_BNEEX);
      end
      S_LOGIEX: begin
        alusrca_o = 1'b1; alusrcb_o = 2'b10; zeroext_o = 1'b1;
        aluop_o = 2'b11; logic_or_o = op_i[0];
      end
      S_ADDIWB:  regwrite_o = 1'b1;
      S_JEX:     begin pcsrc_o = 2'b10; pcwrite_o = 1'b1; end
      default:   ;
    endcase
    // Reset silences every enable; selects already show FETCH since state is forced there.
    if (reset_i) begin
      pcwrite_o = 1'b0; irwrite_o = 1'b0; regwrite_o = 1'b0;
      memwrite_o = 1'b0; mem_req_o = 1'b0; illegal_o = 1'b0;
    end
  end

endmodule
